// File: rtl/vlane_pkg.sv
// vlane_pkg: shared definitions for the vector-lane multiply/shift issue path.
//   - vlane_op_e : 5-bit unit opcode encoding (OP_IDLE = 0 resets the unit output)
//   - clog2      : ceiling log2 helper for sizing index fields
package vlane_pkg;

  typedef enum logic [4:0] {
    OP_IDLE   = 5'b00000,
    OP_SLL    = 5'b00001,
    OP_SRL    = 5'b00010,
    OP_SRA    = 5'b00011,
    OP_ROL    = 5'b00100,
    OP_ROR    = 5'b00101,
    OP_MULLO  = 5'b00110,
    OP_MULHI  = 5'b00111,
    OP_MULHU  = 5'b01000,
    OP_MULH16 = 5'b01001,
    OP_MULSAT = 5'b01010,
    OP_SLLSAT = 5'b01011
  } vlane_op_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vlane_mulshift_arb_rr_arbiter.sv
// rr_arbiter: NREQ-wide round-robin grant.
//   clk_i, rst_i   : clock, asynchronous active-high reset (pointer -> 0)
//   req_i          : request vector
//   en_i           : grant enable; no grant and no pointer move while low
//   gnt_o          : one-hot grant (zero when nothing granted)
//   gnt_idx_o      : index of granted requester
//   gnt_any_o      : a grant was issued this cycle
// The pointer advances to (granted index + 1) mod NREQ on every grant.
module rr_arbiter
  import vlane_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic                     en_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [clog2(NREQ)-1:0]   gnt_idx_o,
  output logic                     gnt_any_o
);

  localparam int unsigned IDW = clog2(NREQ);

  logic [IDW-1:0] rr_q, rr_d;

  // Two passes: indices at/above the pointer first, then the wrapped ones.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    if (en_i) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_any_o && (i >= 32'(rr_q)) && req_i[i]) begin
          gnt_any_o = 1'b1;
          gnt_idx_o = IDW'(i);
          gnt_o[i]  = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_any_o && (i < 32'(rr_q)) && req_i[i]) begin
          gnt_any_o = 1'b1;
          gnt_idx_o = IDW'(i);
          gnt_o[i]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_any_o) begin
      if (32'(gnt_idx_o) == NREQ - 1) rr_d = '0;
      else                            rr_d = gnt_idx_o + IDW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/vlane_mulshift_arb.sv
// vlane_mulshift_arb: round-robin issue arbiter and two-stage sequencer for a
// shared vector-lane multiply/shift unit.
//   clk, reset              : clock, asynchronous active-high reset
//   req_valid/req_ready     : per-requester handshake (ready is one-hot or zero)
//   req_opA/opB/sa/op/tag   : flattened per-requester operation fields
//   mul_opA/opB/sa/op       : operation driven into the unit (zero when idle)
//   mul_en                  : unit stage enables, bit 0 = en[1]
//   mul_result              : unit result, valid while S1 holds an operation
//   out_valid/out_ready     : in-order result channel
//   out_result/id/tag       : result, originating requester index and tag
// Optional build macro VLANE_MULSHIFT_ARB_PERF_EN adds saturating counters
//   perf_busy (cycles with an op in flight) and perf_stall (cycles with a
//   request pending and nothing granted).
module vlane_mulshift_arb
  import vlane_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LOG2WIDTH = 5,
  parameter int unsigned TAGW      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_opA,
  input  logic [NREQ*WIDTH-1:0]     req_opB,
  input  logic [NREQ*LOG2WIDTH-1:0] req_sa,
  input  logic [NREQ*5-1:0]         req_op,
  input  logic [NREQ*TAGW-1:0]      req_tag,
  output logic [WIDTH-1:0]          mul_opA,
  output logic [WIDTH-1:0]          mul_opB,
  output logic [LOG2WIDTH-1:0]      mul_sa,
  output logic [4:0]                mul_op,
  output logic [2:0]                mul_en,
  input  logic [WIDTH-1:0]          mul_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_result,
  output logic [clog2(NREQ)-1:0]    out_id,
  output logic [TAGW-1:0]           out_tag
`ifdef VLANE_MULSHIFT_ARB_PERF_EN
  ,
  output logic [31:0]               perf_busy,
  output logic [31:0]               perf_stall
`endif
);

  localparam int unsigned IDW = clog2(NREQ);

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [TAGW-1:0] gnt_tag;

  logic             s1_valid_q, s1_valid_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic [TAGW-1:0]  s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic [IDW-1:0]   s2_id_q, s2_id_d;
  logic [TAGW-1:0]  s2_tag_q, s2_tag_d;

  logic s2_free, en1, en2, en3;

  // Enables are forced low during reset so nothing is granted or driven
  // while registers are held cleared.
  assign s2_free = !s2_valid_q || out_ready;
  assign en1     = !reset && (!s1_valid_q || s2_free);
  assign en2     = !reset && s1_valid_q && s2_free;
  assign en3     = !reset && s2_valid_q && out_ready;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i     (clk),
    .rst_i     (reset),
    .req_i     (req_valid),
    .en_i      (en1),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign req_ready = gnt_oh;
  assign mul_en    = {en3, en2, en1};

  // One-hot AND-OR mux; an all-zero grant yields zero operands and OP_IDLE.
  always_comb begin
    mul_opA = '0;
    mul_opB = '0;
    mul_sa  = '0;
    mul_op  = OP_IDLE;
    gnt_tag = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        mul_opA = mul_opA | req_opA[i*WIDTH +: WIDTH];
        mul_opB = mul_opB | req_opB[i*WIDTH +: WIDTH];
        mul_sa  = mul_sa  | req_sa[i*LOG2WIDTH +: LOG2WIDTH];
        mul_op  = mul_op  | req_op[i*5 +: 5];
        gnt_tag = gnt_tag | req_tag[i*TAGW +: TAGW];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_tag_d   = s1_tag_q;
    if (en1) begin
      s1_valid_d = gnt_any;
      s1_id_d    = gnt_idx;
      s1_tag_d   = gnt_tag;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_id_d     = s2_id_q;
    s2_tag_d    = s2_tag_q;
    if (en2) begin
      s2_valid_d  = 1'b1;
      s2_result_d = mul_result;
      s2_id_d     = s1_id_q;
      s2_tag_d    = s1_tag_q;
    end else if (en3) begin
      s2_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_id_q     <= '0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_id_q     <= s2_id_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_id     = s2_id_q;
  assign out_tag    = s2_tag_q;

`ifdef VLANE_MULSHIFT_ARB_PERF_EN
  logic [31:0] busy_q, busy_d, stall_q, stall_d;

  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if ((s1_valid_q || s2_valid_q) && (busy_q != '1)) busy_d = busy_q + 32'd1;
    if ((|req_valid) && !(|req_ready) && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy  = busy_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: doc/vlane_mulshift_arb.md
# vlane_mulshift_arb

Round-robin issue arbiter and pipeline sequencer for one shared vector-lane multiply/shift unit. It accepts operations from `NREQ` requesters, such as the lane's mul issue queue and shift issue queue. Each accepted operation is driven into the unit, and the block generates the unit's per-stage enables `en[3:1]`. Results return in order on a single valid/ready output channel carrying the originating requester id and tag. The block sits between the lane issue logic and the mul/shift unit, and absorbs downstream backpressure without losing or duplicating operations.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..8)
- `WIDTH`, 32, datapath width
- `LOG2WIDTH`, 5, shift-amount width
- `TAGW`, 4, per-operation tag width

Ports:
- `clk`  in  1  clock; all state on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester operation valid
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero
- `req_opA`, `req_opB`  in  NREQ*WIDTH  operands, flattened (requester i at `[i*WIDTH +: WIDTH]`)
- `req_sa`  in  NREQ*LOG2WIDTH  shift amounts, flattened
- `req_op`  in  NREQ*5  unit opcodes, flattened
- `req_tag`  in  NREQ*TAGW  tags, flattened
- `mul_opA`, `mul_opB`  out  WIDTH  operands driven to the unit
- `mul_sa`  out  LOG2WIDTH  shift amount driven to the unit
- `mul_op`  out  5  opcode driven to the unit
- `mul_en`  out  3  unit stage enables (bit 0 = en[1])
- `mul_result`  in  WIDTH  unit result; valid while stage S1 holds an operation
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accept
- `out_result`  out  WIDTH  result
- `out_id`  out  clog2(NREQ)  index of the originating requester
- `out_tag`  out  TAGW  tag of the originating operation

## Operation
- Pipeline has two tracked stages:
  - S1: operation resident in the unit's input register. State: `s1_valid`, id, tag.
  - S2: this block's output register. State: `s2_valid`, result, id, tag.
- Stage advance conditions:
  - `s2_free = !s2_valid || out_ready`
  - `en[1] = !s1_valid || s2_free`
  - `en[2] = s1_valid && s2_free`
  - `en[3] = out_valid && out_ready`
- Arbitration:
  - Round-robin over the requesters with `req_valid` high, starting at pointer `rr`.
  - Grant only when `en[1]` is high.
  - `req_ready[g]` is high for the granted requester `g` only.
  - On accept, `rr` becomes `(g+1) mod NREQ`.
  - `rr` does not change when there is no grant.
- Unit drive:
  - `mul_opA/opB/sa/op` are a combinational mux from the granted requester.
  - With no grant, they drive 0; op 0 resets the unit's output.
- On an `en[1]` edge:
  - `s1_valid` takes the value "grant occurred".
  - S1 id/tag are loaded from the granted requester.
- On an `en[2]` edge: S2 captures `mul_result`, id and tag, and `s2_valid` is set to 1.
- If S2 drains with no S1 transfer on the same edge, `s2_valid` is cleared to 0.
- While `en[1]` is low, the unit holds its internal state, so `mul_result` stays stable.
- Opcode contents, including half-width and saturating ops, pass through unmodified; the block never inspects them.
- Reset:
  - All valids clear and `rr` = 0.
  - `req_ready`, `mul_*`, `out_*` are all 0 while reset is high, including `mul_en`.
  - Operations in flight at reset assertion are discarded.
  - The parent ties the unit's `resetn` to `~reset`.

## Timing
- Latency: an operation accepted in cycle t shows `out_valid` in cycle t+2 at the earliest.
- Throughput: one operation per cycle while `out_ready` is held high.
- Backpressure, with `out_ready` low:
  - S2 holds its contents.
  - The next operation fills S1.
  - Then `en[1]` and `en[2]` drop and `req_ready` goes all-zero.
  - At most 2 operations are in flight.
- When `out_ready` rises, in the same cycle:
  - S1 moves to S2.
  - A new grant is allowed.
  - Bubble-free, no loss, no duplication.
- Arbitration uses only the current cycle's `req_valid`; there is no request latching.
- A requester may drop `req_valid` without being granted.

## Configuration
- `VLANE_MULSHIFT_ARB_PERF_EN` defined: the block adds outputs `perf_busy` (32 bits) and `perf_stall` (32 bits).
  - `perf_busy` increments each cycle in which `s1_valid || s2_valid`.
  - `perf_stall` increments each cycle in which any `req_valid` is high and `req_ready` is zero.
  - Both counters saturate at all-ones and clear on reset.
- Macro undefined: neither port nor counter exists, and all other behaviour is identical.

## Structure
- Shared package `vlane_pkg` holds:
  - the 5-bit op encoding constants (zero/idle op = 0)
  - the `clog2` helper function
- One sub-module, `rr_arbiter`: `NREQ`-wide round-robin grant with pointer update on an enable input. Everything else is flat.

## Test plan
- Single op, requester 0, op MULLO (5'b00110), A=7, B=6, tag=3, accepted at t → `out_valid` at t+2 with result=42, id=0, tag=3.
- Both requesters valid continuously, `out_ready`=1 → grants alternate 0,1,0,1; one result per cycle, in order, with tags matching.
- `out_ready` low for 4 cycles while 4 ops are offered → exactly 2 accepted, `req_ready` then 0, `mul_en`=0; after release, the results come out in order with no loss.
- Shift-right-arith (op 5'b00011), A=0x80000000, sa=4 → result 0xF8000000.
- Reset asserted with S1 and S2 both full → `out_valid`=0 and `req_ready`=0 immediately; after release, `rr`=0 and the first grant goes to requester 0.
- With `VLANE_MULSHIFT_ARB_PERF_EN`: 5 ops with 3 stall cycles → `perf_stall`=3 and `perf_busy` equals the number of cycles with an op in flight.
